imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the SPRAM instruction memory. SPRAM cannot be initialised by configuration, so after reset this block copies `WORDS` 32-bit instructions from an initialised block-RAM boot ROM into instruction memory and holds the core stalled. It then hands the instruction-memory address/data path over to the core's fetch stage. It owns the instruction memory's `addr`/`wr_en`/`data_in` inputs and consumes its `data_out`.

## Interface
Parameters:
- `WORDS`, default 1024: number of words copied. Legal range 1..16384.
- `ADDR_W`, default 14: word-address width of the instruction memory and the ROM.

Ports (reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rom_addr`  out  ADDR_W  boot ROM word address. The ROM is a synchronous read with 1-cycle latency.
- `rom_data`  in  32  boot ROM read data for the address presented on the previous cycle.
- `imem_addr`  out  ADDR_W  to instruction memory `addr`.
- `imem_wr_en`  out  1  to instruction memory `wr_en`.
- `imem_data_in`  out  32  to instruction memory `data_in`.
- `imem_data_out`  in  32  from instruction memory `data_out`. This is a synchronous read with 1-cycle latency.
- `fetch_addr`  in  ADDR_W  core fetch word address.
- `fetch_data`  out  32  instruction returned to the core.
- `boot_done`  out  1  high once loading is complete. The core stalls while it is low.
- `boot_error`  out  1  sticky readback-mismatch flag.

## Operation
- States: `COPY`, `VERIFY` (only when the verify macro is defined), `DONE`. Reset enters `COPY` with the read counter at 0.
- `COPY` is pipelined.
  - Each cycle it presents `rom_addr` = read counter, then increments the counter until it reaches `WORDS`.
  - One cycle later it writes: `imem_wr_en`=1, `imem_addr` = the delayed counter, `imem_data_in` = `rom_data`.
  - After the write to address `WORDS-1`, it moves to `VERIFY` or `DONE`.
- `DONE`:
  - `imem_addr` = `fetch_addr`, selected combinationally.
  - `imem_wr_en`=0.
  - `fetch_data` = `imem_data_out`.
  - `rom_addr` is held at 0.
- Before `DONE`: `fetch_data` = 32'h0000_0013 (NOP), and `fetch_addr` is ignored.
- `imem_data_in` is don't-care whenever `imem_wr_en`=0.
- Counters are `ADDR_W+1` bits wide so that `WORDS`=16384 terminates. Addresses never wrap.
- Reset values:
  - `boot_done`=0, `boot_error`=0, `imem_wr_en`=0.
  - `imem_addr`=0, `rom_addr`=0.
  - `fetch_data`=NOP.
- Reset mid-copy: `imem_wr_en` drops immediately (asynchronously) and the copy restarts from address 0 after release. Partially written contents are simply overwritten.
- Reset in `DONE`: the block reloads the whole image, and `boot_done` falls immediately.

## Timing
- Cycle 0 is the first rising edge with `rst` low.
- `rom_addr` = k is presented in cycle k, for k = 0..WORDS-1.
- `imem_wr_en`=1 in cycles 1..WORDS, writing address k in cycle k+1. Exactly `WORDS` writes occur, with no gaps and no duplicates.
- Without verify: `boot_done` is registered and goes high in cycle WORDS+1, then stays high until reset.
- In `DONE`: `fetch_data` reflects `fetch_addr` from the previous cycle, giving 1-cycle fetch latency.
- `boot_done` never rises while a write is still pending.

## Configuration
Macro: `IMEM_LOADER_VERIFY_EN`.

Defined:
- After `COPY`, the block enters `VERIFY` and presents address k to both the ROM and `imem_addr` (with `imem_wr_en`=0) in cycle WORDS+1+k.
- One cycle later it compares `rom_data` with `imem_data_out`. Any mismatch sets `boot_error`, which stays set until reset.
- `boot_done` goes high in cycle 2·WORDS+2 regardless of errors. The core decides what to do about `boot_error`.

Undefined:
- There is no `VERIFY` state.
- `boot_error` is tied to 0.
- The timing is as in the Timing section.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum (`COPY`, `VERIFY`, `DONE`);
  - the NOP constant 32'h0000_0013;
  - the default `ADDR_W`.
- No sub-module: the FSM, counters and output mux are a single module.
- The boot ROM (block RAM with an initial image) is a separate wrapper instantiated alongside the loader at top level, not inside it.

## Test plan
- `WORDS`=8, ROM[k] = 32'hA000_0000+k; release reset:
  - writes to addresses 0..7 in cycles 1..8 with data A000_0000..A000_0007;
  - `boot_done` high in cycle 9;
  - no other `imem_wr_en` pulses.
- After `boot_done`, drive `fetch_addr`=5, then 2: `fetch_data` = A000_0005, then A000_0002, each one cycle later.
- `fetch_addr`=3 during `COPY`: `fetch_data` = 32'h0000_0013 and `imem_addr` follows the loader, not the fetch address.
- Assert `rst` in cycle 4 of an 8-word copy: `imem_wr_en` goes 0 immediately. After release, addresses restart at 0 and all 8 words are rewritten.
- With `IMEM_LOADER_VERIFY_EN` and a memory model that corrupts address 6 (bit 0 flipped): `boot_error`=1 and `boot_done`=1 in cycle 18. A clean run gives `boot_error`=0.
- `WORDS`=1 and `WORDS`=16384:
  - a single write then `boot_done` in cycle 2;
  - the full range 0..16383 written, no address wrap, and `boot_done` in cycle 16385.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    StCopy,
    StVerify,
    StDone
  } state_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam int unsigned DefAddrW = 14;

endpackage

// File: rtl/imem_loader.sv
// Copies WORDS boot-ROM words into SPRAM instruction memory, then hands the port to fetch.
// Define IMEM_LOADER_VERIFY_EN to add a readback pass that raises a sticky boot_error.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WORDS  = 1024,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_wr_en_o,
  output logic [31:0]       imem_data_in_o,
  input  logic [31:0]       imem_data_out_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [31:0]       fetch_data_o,
  output logic              boot_done_o,
  output logic              boot_error_o
);

  // One bit wider than the address so WORDS = 2**ADDR_W still terminates.
  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t WordsC = cnt_t'(WORDS);
  localparam cnt_t LastC  = cnt_t'(WORDS - 1);

  state_e            state_q;
  cnt_t              rd_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              done_q;
  logic              issue;
  logic              last;

  // issue: a ROM read goes out this cycle; pend_q: its data is consumed next cycle.
  assign issue = (state_q != StDone) && (rd_q < WordsC);
  assign last  = pend_q && ({1'b0, pend_addr_q} == LastC);

`ifdef IMEM_LOADER_VERIFY_EN
  logic err_q;
  assign boot_error_o = err_q;
`else
  assign boot_error_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StCopy;
      rd_q        <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      done_q      <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      pend_q <= issue;
      if (issue) begin
        pend_addr_q <= rd_q[ADDR_W-1:0];
        rd_q        <= rd_q + cnt_t'(1);
      end
      unique case (state_q)
        StCopy: begin
          if (last) begin
`ifdef IMEM_LOADER_VERIFY_EN
            state_q <= StVerify;
            rd_q    <= '0;
`else
            state_q <= StDone;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef IMEM_LOADER_VERIFY_EN
        StVerify: begin
          if (pend_q && (rom_data_i != imem_data_out_i)) begin
            err_q <= 1'b1;
          end
          if (last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
`endif
        StDone: ;
        default: state_q <= StCopy;
      endcase
    end
  end

  always_comb begin
    rom_addr_o     = '0;
    imem_addr_o    = pend_addr_q;
    imem_wr_en_o   = 1'b0;
    imem_data_in_o = rom_data_i;
    fetch_data_o   = Nop;
    unique case (state_q)
      StCopy: begin
        if (issue) rom_addr_o = rd_q[ADDR_W-1:0];
        imem_wr_en_o = pend_q;
      end
      StVerify: begin
        if (issue) begin
          rom_addr_o  = rd_q[ADDR_W-1:0];
          imem_addr_o = rd_q[ADDR_W-1:0];
        end
      end
      StDone: begin
        imem_addr_o  = fetch_addr_i;
        fetch_data_o = imem_data_out_i;
      end
      default: ;
    endcase
  end

  assign boot_done_o = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: 8-word main instance plus 1- and 16384-word instances.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned W  = 8;

  function automatic int unsigned done_cyc(input int unsigned w);
`ifdef IMEM_LOADER_VERIFY_EN
    return 2 * w + 2;
`else
    return w + 1;
`endif
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] seed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rv(input int unsigned k);
    return (32'(k) * 32'h9E37_79B9) ^ seed;
  endfunction

  // ---------------- main 8-word instance ----------------
  logic [AW-1:0] rom_addr, imem_addr, fetch_addr;
  logic [31:0]   rom_data, imem_data_in, imem_data_out, fetch_data;
  logic          imem_wr_en, boot_done, boot_error;

  imem_loader #(.WORDS(W), .ADDR_W(AW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .imem_addr_o    (imem_addr),
    .imem_wr_en_o   (imem_wr_en),
    .imem_data_in_o (imem_data_in),
    .imem_data_out_i(imem_data_out),
    .fetch_addr_i   (fetch_addr),
    .fetch_data_o   (fetch_data),
    .boot_done_o    (boot_done),
    .boot_error_o   (boot_error)
  );

  logic [31:0] rom_img [W];
  logic [31:0] imem [1 << AW];
  bit          corrupt6 = 1'b0;

  always @(posedge clk) begin
    rom_data <= (rom_addr < AW'(W)) ? rom_img[rom_addr[2:0]] : 32'hDEAD_BEEF;
    if (imem_wr_en)
      imem[imem_addr] <= (corrupt6 && imem_addr == AW'(6)) ? imem_data_in ^ 32'h1 : imem_data_in;
    imem_data_out <= imem[imem_addr];
  end

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } xact_t;

  xact_t       wr_q[$];
  xact_t       fe_q[$];
  int unsigned edge_n;
  bit          done_seen;
  logic        exp_err;

  always @(posedge clk or posedge rst)
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;

  always @(negedge clk) begin
    xact_t e;
    if (!rst) begin
      if (imem_wr_en) begin
        if (wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_write: addr %0d in cycle %0d, expected no write", imem_addr,
                   edge_n);
        end else begin
          e = wr_q.pop_front();
          check("wr_cycle", edge_n, e.cyc);
          check("wr_addr", 32'(imem_addr), 32'(e.addr));
          check("wr_data", imem_data_in, e.data);
        end
      end
      if (!boot_done) begin
        check("nop_before_done", fetch_data, Nop);
      end else if (!done_seen) begin
        done_seen = 1'b1;
        check("done_cycle", edge_n, done_cyc(W));
        check("writes_left_at_done", wr_q.size(), 0);
        check("boot_error", boot_error, exp_err);
      end
      if (fe_q.size() != 0 && fe_q[0].cyc == edge_n) begin
        e = fe_q.pop_front();
        check("fetch_data", fetch_data, e.data);
      end
    end
  end

  task automatic start_run(input bit corrupt);
    rst = 1'b1;
    fetch_addr = AW'(3);
    corrupt6 = corrupt;
    wr_q.delete();
    fe_q.delete();
    done_seen = 1'b0;
    exp_err = corrupt;
    for (int k = 0; k < W; k++) rom_img[k] = $urandom;
    for (int k = 0; k < W; k++) wr_q.push_back('{cyc: 32'(k + 1), addr: AW'(k), data: rom_img[k]});
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      #1 n++;
    end
    if (!done_seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: boot_done low after %0d cycles, expected high", n);
    end
  endtask

  // Expected fetch data comes from the ROM image the bench generated.
  task automatic do_fetch(input int unsigned a);
    @(posedge clk);
    #1 fetch_addr = AW'(a);
    fe_q.push_back('{cyc: 32'(edge_n + 1), addr: AW'(a), data: rom_img[a]});
  endtask

  task automatic drain_fetches;
    repeat (3) @(posedge clk);
    #1 check("fetch_queue_empty", fe_q.size(), 0);
  endtask

  task automatic reset_at(input int unsigned cyc);
    do begin
      @(posedge clk);
      #1;
    end while (edge_n < cyc);
    check("wr_en_before_rst", imem_wr_en, 1'b1);
    rst = 1'b1;
    #1 check("wr_en_async_drop", imem_wr_en, 1'b0);
  endtask

  // ---------------- 1-word and 16384-word instances ----------------
  int unsigned edge2;
  always @(posedge clk or posedge rst2)
    if (rst2) edge2 <= 0;
    else      edge2 <= edge2 + 1;

  for (genvar g = 0; g < 2; g++) begin : g_side
    localparam int unsigned WG = (g == 0) ? 1 : 16384;
    logic [AW-1:0] s_rom_addr, s_imem_addr;
    logic [31:0]   s_rom_data, s_din, s_dout, s_fetch_data;
    logic          s_wr, s_done, s_err;
    logic [31:0]   s_mem [1 << AW];
    int unsigned   next_k = 0;
    bit            seen = 1'b0;

    imem_loader #(.WORDS(WG), .ADDR_W(AW)) u_side (
      .clk            (clk),
      .rst            (rst2),
      .rom_addr_o     (s_rom_addr),
      .rom_data_i     (s_rom_data),
      .imem_addr_o    (s_imem_addr),
      .imem_wr_en_o   (s_wr),
      .imem_data_in_o (s_din),
      .imem_data_out_i(s_dout),
      .fetch_addr_i   ('0),
      .fetch_data_o   (s_fetch_data),
      .boot_done_o    (s_done),
      .boot_error_o   (s_err)
    );

    always @(posedge clk) begin
      s_rom_data <= rv(32'(s_rom_addr));
      if (s_wr) s_mem[s_imem_addr] <= s_din;
      s_dout <= s_mem[s_imem_addr];
    end

    always @(negedge clk) begin
      if (!rst2) begin
        if (s_wr) begin
          check("side_wr_addr", 32'(s_imem_addr), next_k);
          check("side_wr_data", s_din, rv(next_k));
          next_k++;
        end
        if (s_done && !seen) begin
          seen = 1'b1;
          check("side_done_cycle", edge2, done_cyc(WG));
          check("side_write_count", next_k, WG);
          check("side_boot_error", s_err, 1'b0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    seed = $urandom;
    fetch_addr = '0;
    #1;
    check("rst_boot_done", boot_done, 1'b0);
    check("rst_boot_error", boot_error, 1'b0);
    check("rst_wr_en", imem_wr_en, 1'b0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_fetch_data", fetch_data, Nop);

    @(posedge clk);
    #1 rst2 = 1'b0;

    // Plain load, then directed and random fetches.
    start_run(1'b0);
    wait_done(100);
    do_fetch(5);
    do_fetch(2);
    for (int i = 0; i < 6; i++) do_fetch($urandom_range(0, W - 1));
    drain_fetches();

    // Reset in cycle 4, then at a random cycle; each time the full image must be rewritten.
    start_run(1'b0);
    reset_at(4);
    start_run(1'b0);
    wait_done(100);
    for (int i = 0; i < 4; i++) do_fetch($urandom_range(0, W - 1));
    drain_fetches();

    start_run(1'b0);
    reset_at($urandom_range(1, W));
    start_run(1'b0);
    wait_done(100);
    for (int i = 0; i < 4; i++) do_fetch($urandom_range(0, W - 1));
    drain_fetches();

`ifdef IMEM_LOADER_VERIFY_EN
    // Corrupted readback must flag; a following clean load must clear it.
    start_run(1'b1);
    wait_done(100);
    start_run(1'b0);
    wait_done(100);
    do_fetch(6);
    drain_fetches();
`endif

    begin
      int unsigned n = 0;
      while (!(g_side[0].seen && g_side[1].seen) && n < 40000) begin
        @(negedge clk);
        #1 n++;
      end
      if (!(g_side[0].seen && g_side[1].seen)) begin
        tests++;
        fails++;
        $display("FAIL side_done_timeout: done flags %b%b, expected 11", g_side[1].seen,
                 g_side[0].seen);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
